// File: rtl/patt_arb_pkg.sv
// Shared types and helpers for the patt_arb pattern-scan scheduler.
package patt_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam int              PLEN_DEF = 4;
    localparam logic [PLEN_DEF-1:0] PATT_DEF = 4'b1011;

    // First set request at or after ptr, searching cyclically over n requesters.
    function automatic logic [31:0] rr_pick(input logic [31:0] req,
                                            input logic [31:0] ptr,
                                            input logic [31:0] n);
        logic        found;
        logic [31:0] idx;
        rr_pick = ptr;
        found   = 1'b0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((i < n) && !found) begin
                idx = ptr + i;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (req[idx[4:0]]) begin
                    rr_pick = idx;
                    found   = 1'b1;
                end
            end
        end
    endfunction

endpackage

// File: rtl/patt_match.sv
// Serial overlapping pattern matcher: history window, fill counter, saturating hit count.
module patt_match
    import patt_arb_pkg::*;
#(
    parameter int              PLEN = PLEN_DEF,
    parameter logic [PLEN-1:0] PATT = PATT_DEF,
    parameter int              CW   = 4
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          clr,
    input  logic          vld,
    input  logic          bit_in,
    output logic          hit,
    output logic [CW-1:0] cnt
);

    localparam int FW = $clog2(PLEN + 1);

    logic [PLEN-2:0] hist_q, hist_d;
    logic [FW-1:0]   fill_q, fill_d;
    logic [CW-1:0]   cnt_q,  cnt_d;
    logic [PLEN-1:0] window;

    // Only the previous PLEN-1 bits are stored; the incoming bit completes the window.
    always_comb begin
        window = {hist_q, bit_in};
        hit    = vld && (fill_q >= FW'(PLEN - 1)) && (window == PATT);
        hist_d = hist_q;
        fill_d = fill_q;
        cnt_d  = cnt_q;
        if (clr) begin
            hist_d = '0;
            fill_d = '0;
            cnt_d  = '0;
        end else if (vld) begin
            hist_d = window[PLEN-2:0];
            if (fill_q != FW'(PLEN)) begin
                fill_d = fill_q + 1'b1;
            end
            if (hit && (cnt_q != '1)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            hist_q <= '0;
            fill_q <= '0;
            cnt_q  <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            cnt_q  <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/patt_arb.sv
// Round-robin scheduler feeding request words MSB-first into one serial matcher.
// Define PATT_ARB_FIRST_STOP_EN to end each scan on the first match.
module patt_arb
    import patt_arb_pkg::*;
#(
    parameter int              N    = 4,
    parameter int              W    = 8,
    parameter int              PLEN = PLEN_DEF,
    parameter logic [PLEN-1:0] PATT = PATT_DEF,
    localparam int             IW   = $clog2(N),
    localparam int             CW   = $clog2(W + 1)
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic [N-1:0]    req,
    input  logic [N*W-1:0]  data,
    output logic [N-1:0]    ack,
    output logic            busy,
    output logic            done,
    output logic [IW-1:0]   done_id,
    output logic [CW-1:0]   match_cnt
);

`ifdef PATT_ARB_FIRST_STOP_EN
    localparam bit FIRST_STOP = 1'b1;
`else
    localparam bit FIRST_STOP = 1'b0;
`endif

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [W-1:0]  sreg_q, sreg_d;
    logic [CW-1:0] bitcnt_q, bitcnt_d;
    logic [N-1:0]  ack_q, ack_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [IW-1:0] done_id_q, done_id_d;
    logic [IW-1:0] win;
    logic          clr;
    logic          vld;
    logic          hit;

    patt_match #(
        .PLEN (PLEN),
        .PATT (PATT),
        .CW   (CW)
    ) u_match (
        .clk    (clk),
        .rst_b  (rst_b),
        .clr    (clr),
        .vld    (vld),
        .bit_in (sreg_q[W-1]),
        .hit    (hit),
        .cnt    (match_cnt)
    );

    always_comb begin
        win       = IW'(rr_pick(32'(req), 32'(ptr_q), 32'(N)));
        state_d   = state_q;
        ptr_d     = ptr_q;
        sreg_d    = sreg_q;
        bitcnt_d  = bitcnt_q;
        ack_d     = '0;
        done_id_d = done_id_q;
        clr       = 1'b0;
        vld       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req != '0) begin
                    sreg_d    = data[win*W +: W];
                    done_id_d = win;
                    bitcnt_d  = '0;
                    clr       = 1'b1;
                    ptr_d     = (win == IW'(N - 1)) ? '0 : win + 1'b1;
                    ack_d     = N'(1) << win;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                vld      = 1'b1;
                sreg_d   = sreg_q << 1;
                bitcnt_d = bitcnt_q + 1'b1;
                if ((bitcnt_q == CW'(W - 1)) || (FIRST_STOP && hit)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            sreg_q    <= '0;
            bitcnt_q  <= '0;
            ack_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sreg_q    <= sreg_d;
            bitcnt_q  <= bitcnt_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
        end
    end

    assign ack     = ack_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign done_id = done_id_q;

endmodule

// File: tb/tb_patt_arb.sv
// Directed self-checking bench for patt_arb (default parameters, optional PATT_ARB_FIRST_STOP_EN).
module tb_patt_arb;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;
    localparam int CW = 4;
`ifdef PATT_ARB_FIRST_STOP_EN
    localparam bit FS = 1'b1;
`else
    localparam bit FS = 1'b0;
`endif
    // Expected count / grant-to-done distance for words containing 1011 early and twice.
    localparam int CNT2 = FS ? 1 : 2;
    localparam int LAT2 = FS ? 4 : 8;

    logic            clk = 1'b0;
    logic            rst_b = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*W-1:0]  data = '0;
    logic [N-1:0]    ack;
    logic            busy;
    logic            done;
    logic [IW-1:0]   done_id;
    logic [CW-1:0]   match_cnt;

    int n_chk = 0;
    int n_fail = 0;

    patt_arb #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .req       (req),
        .data      (data),
        .ack       (ack),
        .busy      (busy),
        .done      (done),
        .done_id   (done_id),
        .match_cnt (match_cnt)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst_b = 1'b0;
        @(posedge clk); #1;
        rst_b = 1'b1;
    endtask

    // Watches up to max_c cycles, recording the first ack and the first done; -1 if unseen.
    task automatic observe(input int max_c, input bit drop,
                           output int ack_c, output logic [N-1:0] ack_v,
                           output int done_c, output logic [IW-1:0] id,
                           output logic [CW-1:0] cnt);
        ack_c = -1; ack_v = '0; done_c = -1; id = '0; cnt = '0;
        for (int c = 1; c <= max_c; c++) begin
            @(posedge clk); #1;
            if ((ack != '0) && (ack_c < 0)) begin
                ack_c = c;
                ack_v = ack;
                if (drop) req = req & ~ack;
            end
            if (done) begin
                done_c = c;
                id     = done_id;
                cnt    = match_cnt;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int busy_hi;
        rst_b = 1'b0;
        req   = '0;
        #23;
        n_chk++;
        if ({ack, busy, done, done_id, match_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: ack=%b busy=%b done=%b id=%0d cnt=%0d, required all 0",
                     ack, busy, done, done_id, match_cnt);
        end
        @(posedge clk); #1;
        rst_b   = 1'b1;
        busy_hi = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (busy !== 1'b0) busy_hi++;
        end
        n_chk++;
        if (busy_hi != 0) begin
            n_fail++;
            $display("FAIL idle_quiet: busy high in %0d cycles, required 0", busy_hi);
        end
    endtask

    task automatic test_overlap();
        int ac, dc; logic [N-1:0] av; logic [IW-1:0] id; logic [CW-1:0] cnt;
        data[7:0] = 8'b1011_0110;
        req = 4'b0001;
        observe(30, 1'b1, ac, av, dc, id, cnt);
        n_chk++;
        if (ac !== 1 || av !== 4'b0001) begin
            n_fail++; $display("FAIL ovl_ack: cycle %0d ack %b, required cycle 1 ack 0001", ac, av);
        end
        n_chk++;
        if (dc !== 1 + LAT2) begin
            n_fail++; $display("FAIL ovl_done_cycle: %0d, required %0d", dc, 1 + LAT2);
        end
        n_chk++;
        if (id !== 2'd0 || cnt !== 4'(CNT2)) begin
            n_fail++; $display("FAIL ovl_result: id %0d cnt %0d, required id 0 cnt %0d", id, cnt, CNT2);
        end
        @(posedge clk); #1;
        n_chk++;
        if (done !== 1'b0 || busy !== 1'b0 || match_cnt !== 4'(CNT2) || done_id !== 2'd0) begin
            n_fail++;
            $display("FAIL ovl_hold: done %b busy %b cnt %0d id %0d, required 0 0 %0d 0",
                     done, busy, match_cnt, done_id, CNT2);
        end
    endtask

    task automatic test_round_robin();
        int ac, dc; logic [N-1:0] av; logic [IW-1:0] id; logic [CW-1:0] cnt;
        logic [N-1:0] exp_a;
        do_reset();
        data = {4{8'b1011_1011}};
        req  = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            observe(30, 1'b1, ac, av, dc, id, cnt);
            exp_a = 4'b0001 << k;
            n_chk++;
            if (av !== exp_a || ac !== ((k == 0) ? 1 : 2)) begin
                n_fail++;
                $display("FAIL rr_ack%0d: ack %b at %0d, required %b at %0d", k, av, ac, exp_a, (k == 0) ? 1 : 2);
            end
            n_chk++;
            if (id !== 2'(k) || cnt !== 4'(CNT2) || dc !== ac + LAT2) begin
                n_fail++;
                $display("FAIL rr_done%0d: id %0d cnt %0d at %0d, required id %0d cnt %0d at %0d",
                         k, id, cnt, dc, k, CNT2, ac + LAT2);
            end
        end
        req = 4'b0101;
        observe(30, 1'b1, ac, av, dc, id, cnt);
        n_chk++;
        if (av !== 4'b0001 || id !== 2'd0) begin
            n_fail++; $display("FAIL rr_second_a: ack %b id %0d, required 0001 id 0", av, id);
        end
        observe(30, 1'b1, ac, av, dc, id, cnt);
        n_chk++;
        if (av !== 4'b0100 || id !== 2'd2 || ac !== 2) begin
            n_fail++; $display("FAIL rr_second_b: ack %b id %0d at %0d, required 0100 id 2 at 2", av, id, ac);
        end
    endtask

    task automatic test_no_match();
        int ac, dc; logic [N-1:0] av; logic [IW-1:0] id; logic [CW-1:0] cnt;
        logic [W-1:0] words [4];
        int           exp_c [4];
        words = '{8'b1111_0000, 8'b1011_1011, 8'b0000_0101, 8'b1000_0000};
        exp_c = '{0, CNT2, 0, 0};
        for (int k = 0; k < 4; k++) begin
            data[15:8] = words[k];
            req = 4'b0010;
            observe(30, 1'b1, ac, av, dc, id, cnt);
            n_chk++;
            if (av !== 4'b0010 || id !== 2'd1 || cnt !== 4'(exp_c[k])) begin
                n_fail++;
                $display("FAIL word%0d_%b: ack %b id %0d cnt %0d, required 0010 id 1 cnt %0d",
                         k, words[k], av, id, cnt, exp_c[k]);
            end
        end
        data[15:8] = 8'b1111_0000;
        req = 4'b0010;
        observe(30, 1'b1, ac, av, dc, id, cnt);
        n_chk++;
        if (dc - ac !== 8) begin
            n_fail++; $display("FAIL nomatch_full_len: grant-to-done %0d, required 8", dc - ac);
        end
    endtask

    task automatic test_reset_mid_scan();
        int ac, dc; logic [N-1:0] av; logic [IW-1:0] id; logic [CW-1:0] cnt;
        do_reset();
        data = {4{8'b1011_1011}};
        req  = 4'b0100;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                n_chk++;
                if (ack !== 4'b0100) begin
                    n_fail++; $display("FAIL mid_first_ack: %b, required 0100", ack);
                end
            end
        end
        req   = 4'b1100;
        rst_b = 1'b0;
        #1;
        n_chk++;
        if ({ack, busy, done, done_id, match_cnt} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: ack=%b busy=%b done=%b id=%0d cnt=%0d, required all 0",
                     ack, busy, done, done_id, match_cnt);
        end
        @(posedge clk); #1;
        rst_b = 1'b1;
        observe(30, 1'b1, ac, av, dc, id, cnt);
        n_chk++;
        if (av !== 4'b0100 || ac !== 1) begin
            n_fail++; $display("FAIL mid_regrant: ack %b at %0d, required 0100 at 1", av, ac);
        end
        n_chk++;
        if (dc !== 1 + LAT2 || id !== 2'd2 || cnt !== 4'(CNT2)) begin
            n_fail++;
            $display("FAIL mid_done: at %0d id %0d cnt %0d, required at %0d id 2 cnt %0d",
                     dc, id, cnt, 1 + LAT2, CNT2);
        end
        observe(30, 1'b1, ac, av, dc, id, cnt);
        n_chk++;
        if (av !== 4'b1000 || id !== 2'd3) begin
            n_fail++; $display("FAIL mid_next: ack %b id %0d, required 1000 id 3", av, id);
        end
    endtask

`ifdef PATT_ARB_FIRST_STOP_EN
    task automatic test_first_stop();
        int ac, dc; logic [N-1:0] av; logic [IW-1:0] id; logic [CW-1:0] cnt;
        data[7:0] = 8'b1011_0110;
        req = 4'b0001;
        observe(30, 1'b1, ac, av, dc, id, cnt);
        n_chk++;
        if (dc - ac !== 4 || cnt !== 4'd1 || id !== 2'd0) begin
            n_fail++;
            $display("FAIL first_stop: grant-to-done %0d cnt %0d id %0d, required 4 cnt 1 id 0", dc - ac, cnt, id);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_overlap();
        test_round_robin();
        test_no_match();
        test_reset_mid_scan();
`ifdef PATT_ARB_FIRST_STOP_EN
        test_first_stop();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
